feature_reducer: RTL and testbench

//  Parametrised reduction of a conv-layer feature vector (NUM_CHANNELS lanes) to one signed output,

---
 rtl/feature_reducer_pkg.sv | 34 +++
 rtl/feature_reducer_level.sv | 41 ++++
 rtl/feature_reducer.sv | 152 +++++++++++++++
 tb/tb_feature_reducer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feature_reducer_pkg.sv
// Shared types and width/saturation helpers for the feature_reducer slice.
package feature_reducer_pkg;

  typedef enum logic {MODE_BEAT, MODE_FRAME} reduce_mode_e;

  function automatic int unsigned tree_width(input int unsigned fw, input int unsigned n);
    return fw + $clog2(n) + 1;
  endfunction

  function automatic int unsigned acc_width(input int unsigned tw, input int unsigned len);
    return tw + $clog2(len) + 1;
  endfunction

  // Lanes remaining after lvl pairwise-add levels.
  function automatic int unsigned level_lanes(input int unsigned n, input int unsigned lvl);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < lvl; i++) r = (r + 1) / 2;
    return r;
  endfunction

  // Returns {sat, clipped}; clipped is sign-extended to 64 bits.
  function automatic logic [64:0] sat_clip(input logic signed [63:0] value,
                                           input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (value > hi) return {1'b1, hi};
    if (value < lo) return {1'b1, lo};
    return {1'b0, value};
  endfunction

endpackage

// File: rtl/feature_reducer_level.sv
// One registered adder-tree level: pairwise sums, an odd trailing lane passes through.
module reduce_level #(
  parameter int unsigned W    = 20,
  parameter int unsigned N_IN = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            in_valid,
  input  logic [N_IN*W-1:0]               in_data,
  output logic                            out_valid,
  output logic [((N_IN+1)/2)*W-1:0]       out_data
);

  localparam int unsigned NOut = (N_IN + 1) / 2;
  localparam int unsigned PadW = 2 * NOut * W;

  logic [PadW-1:0]   in_pad;
  logic [NOut*W-1:0] sum;

  // Zero-padding turns the odd-lane pass-through into lane + 0.
  assign in_pad = PadW'(in_data);

  always_comb begin
    sum = '0;
    for (int unsigned j = 0; j < NOut; j++) begin
      sum[j*W +: W] = in_pad[2*j*W +: W] + in_pad[(2*j+1)*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= sum;
    end
  end

endmodule

// File: rtl/feature_reducer.sv
// Signed lane reduction with pipelined adder tree, valid/ready stall and frame accumulation.
// Optional output saturation when FEATURE_REDUCER_SAT_EN is defined; otherwise wraps.
module feature_reducer
  import feature_reducer_pkg::*;
#(
  parameter int unsigned              FEATURE_WIDTH = 16,
  parameter int unsigned              NUM_CHANNELS  = 6,
  parameter int unsigned              OUT_WIDTH     = 16,
  parameter logic [NUM_CHANNELS-1:0]  CHAN_SIGN     = 6'b000011,
  parameter int unsigned              FRAME_LEN     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mode_i,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [FEATURE_WIDTH-1:0] features_in [NUM_CHANNELS],
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_WIDTH-1:0]     out_feature,
  output logic                            out_sat
);

  localparam int unsigned TW = tree_width(FEATURE_WIDTH, NUM_CHANNELS);
  localparam int unsigned L  = $clog2(NUM_CHANNELS);
  localparam int unsigned AW = acc_width(TW, FRAME_LEN);
  localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic stall, accept;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  logic [NUM_CHANNELS*TW-1:0] s0_next, s0_data;
  logic                       s0_valid;

  // Sign-extend before negating so the most negative input negates exactly.
  always_comb begin
    s0_next = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      s0_next[i*TW +: TW] = CHAN_SIGN[i] ? -TW'(features_in[i]) : TW'(features_in[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
    end else if (!stall) begin
      s0_valid <= accept;
      if (accept) s0_data <= s0_next;
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_lvl
    localparam int unsigned NI = level_lanes(NUM_CHANNELS, g);
    localparam int unsigned NO = (NI + 1) / 2;
    logic [NI*TW-1:0] din;
    logic [NO*TW-1:0] dout;
    logic             vin, vout;
    if (g == 0) begin : g_src
      assign din = s0_data;
      assign vin = s0_valid;
    end else begin : g_src
      assign din = g_lvl[g-1].dout;
      assign vin = g_lvl[g-1].vout;
    end
    reduce_level #(
      .W    (TW),
      .N_IN (NI)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (~stall),
      .in_valid  (vin),
      .in_data   (din),
      .out_valid (vout),
      .out_data  (dout)
    );
  end

  logic                 tree_valid;
  logic signed [TW-1:0] tree_data;
  assign tree_valid = g_lvl[L-1].vout;
  assign tree_data  = g_lvl[L-1].dout;

  logic signed [AW-1:0] acc_q, acc_d, acc_base, res_ext, pre;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_base;
  logic                 mode_q, mode_chg, emit;

  // A mode change wipes any partial frame before this edge's result is applied.
  assign mode_chg = mode_i ^ mode_q;
  assign acc_base = mode_chg ? '0 : acc_q;
  assign cnt_base = mode_chg ? '0 : cnt_q;
  assign res_ext  = AW'(tree_data);

  always_comb begin
    pre   = '0;
    emit  = 1'b0;
    acc_d = acc_base;
    cnt_d = cnt_base;
    if (!stall && tree_valid) begin
      if (reduce_mode_e'(mode_i) == MODE_BEAT) begin
        emit = 1'b1;
        pre  = res_ext;
      end else if (cnt_base == CW'(FRAME_LEN - 1)) begin
        emit  = 1'b1;
        pre   = acc_base + res_ext;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_base + res_ext;
        cnt_d = cnt_base + 1'b1;
      end
    end
  end

  logic signed [OUT_WIDTH-1:0] out_next;
  logic                        sat_next;
`ifdef FEATURE_REDUCER_SAT_EN
  logic [64:0] clip;
  assign clip     = sat_clip(64'(pre), OUT_WIDTH);
  assign out_next = clip[OUT_WIDTH-1:0];
  assign sat_next = clip[64];
`else
  assign out_next = OUT_WIDTH'(pre);
  assign sat_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      out_feature <= '0;
      out_sat     <= 1'b0;
    end else begin
      mode_q <= mode_i;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      if (!stall) begin
        out_valid <= emit;
        if (emit) begin
          out_feature <= out_next;
          out_sat     <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_feature_reducer.sv
// Directed self-checking bench for feature_reducer (default signs and an all-add instance).
module tb_feature_reducer;

  localparam int unsigned FW = 16;
  localparam int unsigned NC = 6;
  localparam int unsigned OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_i = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [FW-1:0] features_in [NC];
  logic in_ready, out_valid, out_sat;
  logic signed [OW-1:0] out_feature;
  logic in_ready_u, out_valid_u, out_sat_u;
  logic signed [OW-1:0] out_feature_u;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int q_val[$], q_sat[$], q_cyc[$], qu_val[$], qu_sat[$], acc_cyc[$];

  feature_reducer dut (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode_i),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .features_in (features_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_feature (out_feature),
    .out_sat     (out_sat)
  );

  feature_reducer #(.CHAN_SIGN(6'b000000)) dut_u (
    .clk         (clk),
    .rst         (rst),
    .mode_i      (mode_i),
    .in_valid    (in_valid),
    .in_ready    (in_ready_u),
    .features_in (features_in),
    .out_valid   (out_valid_u),
    .out_ready   (out_ready),
    .out_feature (out_feature_u),
    .out_sat     (out_sat_u)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_val.push_back(int'(out_feature));
      q_sat.push_back(int'(out_sat));
      q_cyc.push_back(cyc);
    end
    if (!rst && out_valid_u && out_ready) begin
      qu_val.push_back(int'(out_feature_u));
      qu_sat.push_back(int'(out_sat_u));
    end
  end

  task automatic check_eq(input string tag, input logic signed [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999999;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_val.delete(); q_sat.delete(); q_cyc.delete();
    qu_val.delete(); qu_sat.delete(); acc_cyc.delete();
  endtask

  task automatic send(input int f0, input int f1, input int f2, input int f3, input int f4,
                      input int f5);
    int n;
    features_in[0] = FW'(f0); features_in[1] = FW'(f1); features_in[2] = FW'(f2);
    features_in[3] = FW'(f3); features_in[4] = FW'(f4); features_in[5] = FW'(f5);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check_eq("send_accept", in_ready, 1);
    acc_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send15();
    send(1, 2, 3, 4, 5, 6);
  endtask

  initial begin
    int n;
    // 1. reset with in_valid held high
    for (int i = 0; i < NC; i++) features_in[i] = 16'sd7;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_feature", out_feature, 0);
      check_eq("rst_out_sat", out_sat, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    idle(8);
    check_eq("rst_no_output", q_val.size(), 0);

    // 2. single beat: 3+4+5+6-1-2
    clear_q();
    send15();
    idle(10);
    check_eq("beat_count", q_val.size(), 1);
    check_eq("beat_value", pick(q_val, 0), 15);
    check_eq("beat_latency", pick(q_cyc, 0) - pick(acc_cyc, 0), 5);
    check_eq("beat_sat", pick(q_sat, 0), 0);
    check_eq("beat_value_alladd", pick(qu_val, 0), 21);

    // 3. back-to-back with a 2-cycle downstream stall
    clear_q();
    send15();
    send(0, 0, 5, 5, 5, 6);
    send(3, 0, 0, 0, 0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("bb_first_valid", out_valid, 1);
    out_ready = 1'b0;
    #1;
    check_eq("bb_in_ready_stall", in_ready, 0);
    @(posedge clk);
    #1;
    check_eq("bb_hold_value", out_feature, 15);
    check_eq("bb_hold_valid", out_valid, 1);
    check_eq("bb_in_ready_stall2", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    idle(10);
    check_eq("bb_count", q_val.size(), 3);
    check_eq("bb_value0", pick(q_val, 0), 15);
    check_eq("bb_value1", pick(q_val, 1), 21);
    check_eq("bb_value2", pick(q_val, 2), -3);
    check_eq("bb_alladd_count", qu_val.size(), 3);
    check_eq("bb_alladd_value2", pick(qu_val, 2), 3);

    // 4. extremes: all-add gives 6x, default signs give 2x
    clear_q();
    send(32767, 32767, 32767, 32767, 32767, 32767);
    send(-32768, -32768, -32768, -32768, -32768, -32768);
    idle(10);
`ifdef FEATURE_REDUCER_SAT_EN
    check_eq("max_alladd_value", pick(qu_val, 0), 32767);
    check_eq("max_alladd_sat", pick(qu_sat, 0), 1);
    check_eq("min_alladd_value", pick(qu_val, 1), -32768);
    check_eq("min_alladd_sat", pick(qu_sat, 1), 1);
    check_eq("max_signed_value", pick(q_val, 0), 32767);
    check_eq("min_signed_value", pick(q_val, 1), -32768);
    check_eq("min_signed_sat", pick(q_sat, 1), 1);
`else
    // 196602 wraps to 16'hFFFA, -196608 wraps to 0
    check_eq("max_alladd_value", pick(qu_val, 0), -6);
    check_eq("max_alladd_sat", pick(qu_sat, 0), 0);
    check_eq("min_alladd_value", pick(qu_val, 1), 0);
    check_eq("min_alladd_sat", pick(qu_sat, 1), 0);
    check_eq("max_signed_value", pick(q_val, 0), -2);
    check_eq("min_signed_value", pick(q_val, 1), 0);
    check_eq("min_signed_sat", pick(q_sat, 1), 0);
`endif

    // 5. frame mode: four results of 15
    clear_q();
    mode_i = 1'b1;
    idle(2);
    repeat (4) send15();
    idle(10);
    check_eq("frame_count", q_val.size(), 1);
    check_eq("frame_value", pick(q_val, 0), 60);
    check_eq("frame_latency", pick(q_cyc, 0) - pick(acc_cyc, 3), 5);

    // 6a. partial frame discarded by reset
    clear_q();
    repeat (2) send15();
    idle(8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_cyc.delete();
    repeat (4) send15();
    idle(10);
    check_eq("frame_rst_count", q_val.size(), 1);
    check_eq("frame_rst_value", pick(q_val, 0), 60);
    check_eq("frame_rst_latency", pick(q_cyc, 0) - pick(acc_cyc, 3), 5);

    // 6b. partial frame discarded by a mode toggle
    clear_q();
    repeat (2) send15();
    idle(8);
    check_eq("frame_partial_silent", q_val.size(), 0);
    mode_i = 1'b0;
    idle(2);
    mode_i = 1'b1;
    idle(2);
    acc_cyc.delete();
    repeat (4) send15();
    idle(10);
    check_eq("frame_mode_count", q_val.size(), 1);
    check_eq("frame_mode_value", pick(q_val, 0), 60);
    check_eq("frame_mode_latency", pick(q_cyc, 0) - pick(acc_cyc, 3), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
